// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, forwarding/hazard enums and helpers for the MIPS-lite core
package mips_pkg;

  localparam int REGADDR    = 5;
  localparam int HALT_DRAIN = 3;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } FwdSel;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } HazState;

  // A later stage supplies a value for src only if it really writes a nonzero register equal to src.
  function automatic logic writes_reg(input logic we,
                                      input logic [REGADDR-1:0] rd,
                                      input logic [REGADDR-1:0] src);
    return we && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// rtl/ex_hazard_ctrl_if.sv - pipeline-status inputs and hazard-control outputs of ex_hazard_ctrl
interface ex_hazard_ctrl_if
  import mips_pkg::*;
#(
  parameter int CNTW = 16
);
  logic [REGADDR-1:0] id_rs;
  logic [REGADDR-1:0] id_rt;
  logic               id_uses_rs;
  logic               id_uses_rt;
  logic               id_halt;
  logic [REGADDR-1:0] ex_rs;
  logic [REGADDR-1:0] ex_rt;
  logic [REGADDR-1:0] ex_rd;
  logic               ex_memread;
  logic               ex_branch_taken;
  logic [REGADDR-1:0] mem_rd;
  logic [REGADDR-1:0] wb_rd;
  logic               mem_regwrite;
  logic               wb_regwrite;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;
  logic               pc_stall;
  logic               ifid_stall;
  logic               idex_bubble;
  logic               ifid_flush;
  logic               halted;
  logic [CNTW-1:0]    stall_count;
  logic [CNTW-1:0]    flush_count;

  // Pipeline side: reports stage contents, consumes the control decisions.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
    output ex_rs, ex_rt, ex_rd, ex_memread, ex_branch_taken,
    output mem_rd, wb_rd, mem_regwrite, wb_regwrite,
    input  fwd_a, fwd_b, pc_stall, ifid_stall, idex_bubble, ifid_flush,
    input  halted, stall_count, flush_count
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
    input  ex_rs, ex_rt, ex_rd, ex_memread, ex_branch_taken,
    input  mem_rd, wb_rd, mem_regwrite, wb_regwrite,
    output fwd_a, fwd_b, pc_stall, ifid_stall, idex_bubble, ifid_flush,
    output halted, stall_count, flush_count
  );
endinterface

// File: rtl/ex_hazard_ctrl_fwd_select.sv
// rtl/ex_hazard_ctrl_fwd_select.sv - operand forwarding select for one EX source register
module fwd_select
  import mips_pkg::*;
(
  input  logic [REGADDR-1:0] ex_src_i,
  input  logic [REGADDR-1:0] mem_rd_i,
  input  logic               mem_regwrite_i,
  input  logic [REGADDR-1:0] wb_rd_i,
  input  logic               wb_regwrite_i,
  output FwdSel              fwd_o
);

  // MEM holds the younger result, so it wins over WB when both match.
  always_comb begin
    fwd_o = FWD_NONE;
    if (writes_reg(mem_regwrite_i, mem_rd_i, ex_src_i)) begin
      fwd_o = FWD_MEM;
    end else if (writes_reg(wb_regwrite_i, wb_rd_i, ex_src_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage forwarding, load-use stall, branch flush and halt-drain controller
module ex_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int CNTW = 16
)(
  input  logic             clk,
  input  logic             reset,
  ex_hazard_ctrl_if.slave  hz
);

  localparam int DW = $clog2(HALT_DRAIN + 1);

  HazState         state_q, state_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            halted_q;
  logic [CNTW-1:0] stall_count_q, stall_count_d;
  logic [CNTW-1:0] flush_count_q, flush_count_d;
  FwdSel           fwd_a_sel, fwd_b_sel;
  logic            load_use;
  logic            stall_inc, flush_inc;
  logic            pc_stall, ifid_stall, idex_bubble, ifid_flush;

  fwd_select u_fwd_a (
    .ex_src_i       (hz.ex_rs),
    .mem_rd_i       (hz.mem_rd),
    .mem_regwrite_i (hz.mem_regwrite),
    .wb_rd_i        (hz.wb_rd),
    .wb_regwrite_i  (hz.wb_regwrite),
    .fwd_o          (fwd_a_sel)
  );

  fwd_select u_fwd_b (
    .ex_src_i       (hz.ex_rt),
    .mem_rd_i       (hz.mem_rd),
    .mem_regwrite_i (hz.mem_regwrite),
    .wb_rd_i        (hz.wb_rd),
    .wb_regwrite_i  (hz.wb_regwrite),
    .fwd_o          (fwd_b_sel)
  );

  // A load in EX whose destination is read by the ID instruction cannot be forwarded in time.
  always_comb begin
    load_use = hz.ex_memread && (hz.ex_rd != '0) &&
               ((hz.id_uses_rs && (hz.ex_rd == hz.id_rs)) ||
                (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
  end

  // Next state and pipeline controls: in RUN a taken branch beats load-use, which beats HALT.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.ex_branch_taken) begin
          // ID/IF hold wrong-path instructions, so their load-use or HALT is meaningless.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else if (hz.id_halt) begin
          // HALT itself moves on to EX; everything fetched behind it is discarded.
          pc_stall    = 1'b1;
          ifid_flush  = 1'b1;
          drain_d     = DW'(HALT_DRAIN);
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        pc_stall    = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        drain_d     = drain_q - 1'b1;
        if (drain_q <= DW'(1)) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        pc_stall    = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      default: begin
        state_d = RUN;
        drain_d = '0;
      end
    endcase
    if (reset) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_inc && (stall_count_q != '1)) stall_count_d = stall_count_q + CNTW'(1);
    if (flush_inc && (flush_count_q != '1)) flush_count_d = flush_count_q + CNTW'(1);
  end

  // Registered state; halted lags entry into HALTED by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      drain_q       <= '0;
      halted_q      <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      halted_q      <= (state_q == HALTED);
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.fwd_a       = reset ? 2'b00 : 2'(fwd_a_sel);
  assign hz.fwd_b       = reset ? 2'b00 : 2'(fwd_b_sel);
  assign hz.pc_stall    = pc_stall;
  assign hz.ifid_stall  = ifid_stall;
  assign hz.idex_bubble = idex_bubble;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.halted      = halted_q;
  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - self-checking bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_hazard_ctrl_if #(.CNTW(16)) hz();

  ex_hazard_ctrl #(.CNTW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  typedef struct {
    logic [4:0] id_rs, id_rt;
    logic       urs, urt;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       ld, br;
    logic [4:0] mem_rd;
    logic       mem_we;
    logic [4:0] wb_rd;
    logic       wb_we;
    logic [1:0] efa, efb;
    logic [3:0] ectl;   // {pc_stall, ifid_stall, idex_bubble, ifid_flush}
  } vec_t;

  vec_t tbl[12];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: cycles elapsed since HALT was accepted (-1 while running) plus counters.
  int          m_since;
  logic [15:0] m_stall, m_flush;

  function automatic vec_t mk(input logic [4:0] id_rs, id_rt, input logic urs, urt,
                              input logic [4:0] ex_rs, ex_rt, ex_rd, input logic ld, br,
                              input logic [4:0] mem_rd, input logic mem_we,
                              input logic [4:0] wb_rd, input logic wb_we,
                              input logic [1:0] efa, efb, input logic [3:0] ectl);
    vec_t v;
    v.id_rs = id_rs; v.id_rt = id_rt; v.urs = urs; v.urt = urt;
    v.ex_rs = ex_rs; v.ex_rt = ex_rt; v.ex_rd = ex_rd; v.ld = ld; v.br = br;
    v.mem_rd = mem_rd; v.mem_we = mem_we; v.wb_rd = wb_rd; v.wb_we = wb_we;
    v.efa = efa; v.efb = efb; v.ectl = ectl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v, input logic halt);
    hz.id_rs = v.id_rs; hz.id_rt = v.id_rt; hz.id_uses_rs = v.urs; hz.id_uses_rt = v.urt;
    hz.id_halt = halt;
    hz.ex_rs = v.ex_rs; hz.ex_rt = v.ex_rt; hz.ex_rd = v.ex_rd;
    hz.ex_memread = v.ld; hz.ex_branch_taken = v.br;
    hz.mem_rd = v.mem_rd; hz.mem_regwrite = v.mem_we;
    hz.wb_rd = v.wb_rd; hz.wb_regwrite = v.wb_we;
  endtask

  task automatic clear_inputs();
    drive(mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0), 1'b0);
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (hz.mem_regwrite && hz.mem_rd != 0 && hz.mem_rd == src) return 2'd2;
    if (hz.wb_regwrite && hz.wb_rd != 0 && hz.wb_rd == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic ref_load_use();
    return hz.ex_memread && hz.ex_rd != 0 &&
           ((hz.id_uses_rs && hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && hz.ex_rd == hz.id_rt));
  endfunction

  // Compare every DUT output with what the model predicts for the current inputs.
  task automatic check_model();
    logic [3:0] ectl;
    logic [1:0] fa, fb;
    fa = reset ? 2'd0 : ref_fwd(hz.ex_rs);
    fb = reset ? 2'd0 : ref_fwd(hz.ex_rt);
    if (reset)                   ectl = 4'b0000;
    else if (m_since >= 0)       ectl = 4'b1011;
    else if (hz.ex_branch_taken) ectl = 4'b0011;
    else if (ref_load_use())     ectl = 4'b1110;
    else if (hz.id_halt)         ectl = 4'b1001;
    else                         ectl = 4'b0000;
    chk("rand_fwd_a", hz.fwd_a, fa);
    chk("rand_fwd_b", hz.fwd_b, fb);
    chk("rand_ctl", {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush}, ectl);
    chk("rand_halted", hz.halted, (m_since >= HALT_DRAIN + 1));
    chk("rand_stall_count", hz.stall_count, m_stall);
    chk("rand_flush_count", hz.flush_count, m_flush);
  endtask

  // Advance the model over the coming edge, then take the edge.
  task automatic tick();
    if (reset) begin
      m_since = -1; m_stall = 0; m_flush = 0;
    end else if (m_since >= 0) begin
      if (m_since < 1000) m_since++;
    end else if (hz.ex_branch_taken) begin
      if (m_flush != 16'hFFFF) m_flush++;
    end else if (ref_load_use()) begin
      if (m_stall != 16'hFFFF) m_stall++;
    end else if (hz.id_halt) begin
      m_since = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m_since = -1; m_stall = 0; m_flush = 0;
    clear_inputs();

    //             id_rs rt urs urt ex_rs rt rd ld br mem_rd we wb_rd we  fa    fb    ctl
    tbl[0]  = mk(0, 0, 0, 0,  5, 7, 0, 0, 0,  5, 1,  5, 1,  2'd2, 2'd0, 4'b0000);
    tbl[1]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1,  0, 1,  2'd0, 2'd0, 4'b0000);
    tbl[2]  = mk(0, 0, 0, 0,  5, 5, 0, 0, 0,  5, 0,  5, 1,  2'd1, 2'd1, 4'b0000);
    tbl[3]  = mk(0, 0, 0, 0,  7, 6, 0, 0, 0,  6, 1,  7, 1,  2'd1, 2'd2, 4'b0000);
    tbl[4]  = mk(0, 0, 0, 0,  0, 9, 0, 0, 0,  0, 1,  0, 1,  2'd0, 2'd0, 4'b0000);
    tbl[5]  = mk(1, 3, 1, 1,  0, 0, 3, 1, 0,  0, 0,  0, 0,  2'd0, 2'd0, 4'b1110);
    tbl[6]  = mk(1, 3, 1, 0,  0, 0, 3, 1, 0,  0, 0,  0, 0,  2'd0, 2'd0, 4'b0000);
    tbl[7]  = mk(1, 3, 1, 1,  0, 0, 3, 1, 1,  0, 0,  0, 0,  2'd0, 2'd0, 4'b0011);
    tbl[8]  = mk(0, 2, 1, 1,  0, 0, 0, 1, 0,  0, 0,  0, 0,  2'd0, 2'd0, 4'b0000);
    tbl[9]  = mk(4, 2, 1, 1,  0, 0, 4, 1, 0,  0, 0,  0, 0,  2'd0, 2'd0, 4'b1110);
    tbl[10] = mk(4, 2, 1, 1,  0, 0, 4, 0, 0,  0, 0,  0, 0,  2'd0, 2'd0, 4'b0000);
    tbl[11] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0,  0, 0,  2'd0, 2'd0, 4'b0011);

    // Reset: controls and forwarding forced low even with a branch and a MEM match present.
    drive(tbl[0], 1'b0);
    hz.ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("reset_ctl", {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush}, 4'b0000);
    chk("reset_fwd_a", hz.fwd_a, 2'd0);
    tick();
    tick();
    chk("reset_halted", hz.halted, 1'b0);
    chk("reset_stall_count", hz.stall_count, 16'd0);
    chk("reset_flush_count", hz.flush_count, 16'd0);
    reset = 1'b0;

    // Table vectors, one cycle each, in RUN.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i], 1'b0);
      @(negedge clk);
      chk($sformatf("tbl%0d_fwd_a", i), hz.fwd_a, tbl[i].efa);
      chk($sformatf("tbl%0d_fwd_b", i), hz.fwd_b, tbl[i].efb);
      chk($sformatf("tbl%0d_ctl", i),
          {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush}, tbl[i].ectl);
      tick();
    end
    clear_inputs();
    @(negedge clk);
    chk("tbl_stall_count", hz.stall_count, 16'd2);
    chk("tbl_flush_count", hz.flush_count, 16'd2);

    // Single load-use stall cycle: counter 0 -> 1, then the bubble clears the load.
    do_reset();
    drive(tbl[5], 1'b0);
    @(negedge clk);
    chk("lu_pc_stall", hz.pc_stall, 1'b1);
    tick();
    hz.ex_memread = 1'b0;
    @(negedge clk);
    chk("lu_after_pc_stall", hz.pc_stall, 1'b0);
    chk("lu_stall_count", hz.stall_count, 16'd1);

    // Halt drain: halted rises HALT_DRAIN+1 edges after HALT is accepted; branches ignored.
    do_reset();
    hz.id_halt = 1'b1;
    @(negedge clk);
    chk("halt_accept_ctl", {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush}, 4'b1001);
    tick();
    hz.id_halt = 1'b0;
    for (int k = 0; k <= HALT_DRAIN + 1; k++) begin
      hz.ex_branch_taken = k[0];
      @(negedge clk);
      chk($sformatf("halt_edge%0d_halted", k + 1), hz.halted, (k == HALT_DRAIN + 1));
      chk($sformatf("halt_edge%0d_ctl", k + 1),
          {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush}, 4'b1011);
      tick();
    end
    chk("halt_flush_count", hz.flush_count, 16'd0);

    // Reset in mid-drain, then halt again normally.
    do_reset();
    hz.id_halt = 1'b1;
    tick();
    hz.id_halt = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("drain_reset_ctl", {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush}, 4'b0000);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("drain_reset_run_ctl", {hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush}, 4'b0000);
    chk("drain_reset_halted", hz.halted, 1'b0);
    hz.id_halt = 1'b1;
    tick();
    hz.id_halt = 1'b0;
    for (int k = 0; k < HALT_DRAIN + 1; k++) tick();
    @(negedge clk);
    chk("rehalt_halted", hz.halted, 1'b1);

    // Flush counter saturation.
    do_reset();
    hz.ex_branch_taken = 1'b1;
    for (int k = 0; k < 65535; k++) tick();
    @(negedge clk);
    chk("sat_flush_ffff", hz.flush_count, 16'hFFFF);
    tick();
    @(negedge clk);
    chk("sat_flush_hold", hz.flush_count, 16'hFFFF);
    chk("sat_stall_zero", hz.stall_count, 16'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset              = ($urandom_range(0, 59) == 0);
      hz.id_rs           = 5'($urandom_range(0, 3));
      hz.id_rt           = 5'($urandom_range(0, 3));
      hz.id_uses_rs      = 1'($urandom_range(0, 1));
      hz.id_uses_rt      = 1'($urandom_range(0, 1));
      hz.id_halt         = ($urandom_range(0, 29) == 0);
      hz.ex_rs           = 5'($urandom_range(0, 3));
      hz.ex_rt           = 5'($urandom_range(0, 3));
      hz.ex_rd           = 5'($urandom_range(0, 3));
      hz.ex_memread      = 1'($urandom_range(0, 1));
      hz.ex_branch_taken = ($urandom_range(0, 3) == 0);
      hz.mem_rd          = 5'($urandom_range(0, 3));
      hz.wb_rd           = 5'($urandom_range(0, 3));
      hz.mem_regwrite    = 1'($urandom_range(0, 1));
      hz.wb_regwrite     = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_model();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
